// File: rtl/pixel_readout_buffer.sv
// 2x2 pixel capture with a capture/output double buffer and a valid/ready pixel stream.
// Optional build macro DARK_SUB_EN: subtract DARK_LEVEL (saturating at 0) from each sample at capture.

module pixel_readout_col #(
  parameter int ADC_WIDTH  = 8,
  parameter int DARK_LEVEL = 16
) (
  input  logic [ADC_WIDTH-1:0] raw,
  output logic [ADC_WIDTH-1:0] cond
);
  if (DARK_LEVEL < 0 || DARK_LEVEL >= (1 << ADC_WIDTH)) begin : g_dark_range
    $error("DARK_LEVEL must fit in ADC_WIDTH bits");
  end

`ifdef DARK_SUB_EN
  localparam logic [ADC_WIDTH-1:0] DARK = ADC_WIDTH'(DARK_LEVEL);
  assign cond = (raw > DARK) ? raw - DARK : '0;
`else
  assign cond = raw;
`endif
endmodule

module pixel_readout_buffer #(
  parameter int ADC_WIDTH  = 8,
  parameter int DARK_LEVEL = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 NRE1,
  input  logic                 NRE2,
  input  logic                 adc,
  input  logic                 erase,
  input  logic [ADC_WIDTH-1:0] col1_data,
  input  logic [ADC_WIDTH-1:0] col2_data,
  output logic [ADC_WIDTH-1:0] pix_data,
  output logic [1:0]           pix_idx,
  output logic                 pix_valid,
  output logic                 pix_last,
  input  logic                 pix_ready,
  output logic                 frame_ovf,
  output logic                 seq_err
);
  localparam int NUM_COLS = 2;

  typedef enum logic [1:0] {WAIT_R1, WAIT_R2, XFER} state_t;

  state_t state, state_nxt;
  logic [NUM_COLS-1:0][ADC_WIDTH-1:0] col_raw, col_cond;
  logic [3:0][ADC_WIDTH-1:0]          cap_bank, out_bank;
  logic                               out_full;
  logic [1:0]                         idx;
  logic row1_ok, row2_ok, hs, bank_free;
  logic cap_r1, cap_r2, load, ovf_nxt, err_nxt;

  assign col_raw = {col2_data, col1_data};

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    pixel_readout_col #(.ADC_WIDTH(ADC_WIDTH), .DARK_LEVEL(DARK_LEVEL)) u_col (
      .raw  (col_raw[c]),
      .cond (col_cond[c])
    );
  end

  assign row1_ok   = adc && !NRE1 && NRE2;
  assign row2_ok   = adc && NRE1 && !NRE2;
  assign hs        = out_full && pix_ready;
  // A bank finishing its last handshake this cycle can take the next frame with no gap.
  assign bank_free = !out_full || (hs && idx == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WAIT_R1;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_R1: if (row1_ok) state_nxt = WAIT_R2;
      WAIT_R2: begin
        if (erase)        state_nxt = WAIT_R1;
        else if (row2_ok) state_nxt = XFER;
      end
      XFER:    state_nxt = WAIT_R1;
      default: state_nxt = WAIT_R1;
    endcase
  end

  always_comb begin
    cap_r1  = 1'b0;
    cap_r2  = 1'b0;
    load    = 1'b0;
    ovf_nxt = 1'b0;
    err_nxt = 1'b0;
    case (state)
      WAIT_R1: begin
        cap_r1  = row1_ok;
        err_nxt = adc && !row1_ok;
      end
      WAIT_R2: begin
        cap_r2  = !erase && row2_ok;
        err_nxt = !erase && adc && !row2_ok;
      end
      XFER: begin
        load    = bank_free;
        ovf_nxt = !bank_free;
        err_nxt = adc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_bank  <= '0;
      out_bank  <= '0;
      out_full  <= 1'b0;
      idx       <= 2'd0;
      frame_ovf <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      frame_ovf <= ovf_nxt;
      seq_err   <= err_nxt;
      if (cap_r1) cap_bank[1:0] <= col_cond;
      if (cap_r2) cap_bank[3:2] <= col_cond;
      if (load) begin
        out_bank <= cap_bank;
        out_full <= 1'b1;
        idx      <= 2'd0;
      end else if (hs) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) out_full <= 1'b0;
      end
    end
  end

  assign pix_valid = out_full;
  assign pix_idx   = idx;
  assign pix_data  = out_full ? out_bank[idx] : '0;
  assign pix_last  = out_full && (idx == 2'd3);
endmodule

// File: tb/tb_pixel_readout_buffer.sv
// Directed bench for pixel_readout_buffer; expected pixels follow DARK_SUB_EN when defined.

module tb_pixel_readout_buffer;
  logic       clk = 1'b0;
  logic       reset, NRE1, NRE2, adc, erase, pix_ready;
  logic [7:0] col1_data, col2_data, pix_data;
  logic [1:0] pix_idx;
  logic       pix_valid, pix_last, frame_ovf, seq_err;
  int n_chk = 0;
  int n_fail = 0;

  pixel_readout_buffer #(.ADC_WIDTH(8), .DARK_LEVEL(16)) dut (
    .clk(clk), .reset(reset), .NRE1(NRE1), .NRE2(NRE2), .adc(adc), .erase(erase),
    .col1_data(col1_data), .col2_data(col2_data), .pix_data(pix_data), .pix_idx(pix_idx),
    .pix_valid(pix_valid), .pix_last(pix_last), .pix_ready(pix_ready),
    .frame_ovf(frame_ovf), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ex(input int v);
`ifdef DARK_SUB_EN
    return (v > 16) ? 8'(v - 16) : 8'd0;
`else
    return 8'(v);
`endif
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Strobe is launched just after an edge and sampled on the next one; returns 1ns after that edge.
  task automatic strobe(input logic n1, input logic n2, input logic [7:0] c1, input logic [7:0] c2);
    adc = 1'b1; NRE1 = n1; NRE2 = n2; col1_data = c1; col2_data = c2;
    step();
    adc = 1'b0; NRE1 = 1'b1; NRE2 = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; NRE1 = 1'b1; NRE2 = 1'b1; adc = 1'b0; erase = 1'b0; pix_ready = 1'b0;
    col1_data = '0; col2_data = '0;
    step(); step();
    n_chk++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", pix_valid); end
    n_chk++; if (pix_data !== 8'd0) begin n_fail++; $display("FAIL reset_data got %0d want 0", pix_data); end
    n_chk++; if (pix_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", pix_idx); end
    n_chk++; if (pix_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", pix_last); end
    n_chk++; if (frame_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", frame_ovf); end
    n_chk++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL reset_seq got %b want 0", seq_err); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] e [4];
    e = '{ex(40), ex(50), ex(60), ex(70)};
    pix_ready = 1'b1;
    strobe(1'b0, 1'b1, 8'd40, 8'd50);
    strobe(1'b1, 1'b0, 8'd60, 8'd70);
    n_chk++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency1 got %b want 0", pix_valid); end
    step();
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (pix_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d] got %b want 1", i, pix_valid); end
      n_chk++; if (pix_data !== e[i]) begin n_fail++; $display("FAIL basic_data[%0d] got %0d want %0d", i, pix_data, e[i]); end
      n_chk++; if (pix_idx !== 2'(i)) begin n_fail++; $display("FAIL basic_idx[%0d] got %0d want %0d", i, pix_idx, i); end
      n_chk++; if (pix_last !== (i == 3)) begin n_fail++; $display("FAIL basic_last[%0d] got %b want %b", i, pix_last, i == 3); end
      step();
    end
    n_chk++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL basic_done got %b want 0", pix_valid); end
  endtask

  task automatic test_stall();
    logic [7:0] e [4];
    e = '{ex(11), ex(22), ex(33), ex(44)};
    pix_ready = 1'b0;
    strobe(1'b0, 1'b1, 8'd11, 8'd22);
    strobe(1'b1, 1'b0, 8'd33, 8'd44);
    step();
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (pix_valid !== 1'b1 || pix_idx !== 2'd0 || pix_data !== e[0])
        begin n_fail++; $display("FAIL stall_hold0[%0d] got v%b i%0d d%0d want v1 i0 d%0d", k, pix_valid, pix_idx, pix_data, e[0]); end
      step();
    end
    pix_ready = 1'b1;
    step();
    pix_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_chk++; if (pix_idx !== 2'd1 || pix_data !== e[1])
        begin n_fail++; $display("FAIL stall_hold1[%0d] got i%0d d%0d want i1 d%0d", k, pix_idx, pix_data, e[1]); end
      step();
    end
    pix_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      n_chk++; if (pix_valid !== 1'b1 || pix_idx !== 2'(i) || pix_data !== e[i])
        begin n_fail++; $display("FAIL stall_resume[%0d] got v%b i%0d d%0d want v1 i%0d d%0d", i, pix_valid, pix_idx, pix_data, i, e[i]); end
      step();
    end
    n_chk++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL stall_done got %b want 0", pix_valid); end
  endtask

  task automatic test_overflow();
    logic [7:0] e [4];
    e = '{ex(100), ex(101), ex(102), ex(103)};
    pix_ready = 1'b0;
    strobe(1'b0, 1'b1, 8'd100, 8'd101);
    strobe(1'b1, 1'b0, 8'd102, 8'd103);
    step();
    strobe(1'b0, 1'b1, 8'd5, 8'd6);
    strobe(1'b1, 1'b0, 8'd7, 8'd8);
    n_chk++; if (frame_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", frame_ovf); end
    step();
    n_chk++; if (frame_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %b want 1", frame_ovf); end
    step();
    n_chk++; if (frame_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", frame_ovf); end
    pix_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (pix_valid !== 1'b1 || pix_idx !== 2'(i) || pix_data !== e[i])
        begin n_fail++; $display("FAIL ovf_first[%0d] got v%b i%0d d%0d want v1 i%0d d%0d", i, pix_valid, pix_idx, pix_data, i, e[i]); end
      step();
    end
    n_chk++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped got %b want 0", pix_valid); end
  endtask

  task automatic test_seq_err();
    logic [7:0] e [4];
    e = '{ex(31), ex(32), ex(33), ex(34)};
    pix_ready = 1'b1;
    strobe(1'b1, 1'b0, 8'd9, 8'd9);
    n_chk++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_r2first got %b want 1", seq_err); end
    step();
    n_chk++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL seq_clear got %b want 0", seq_err); end
    strobe(1'b0, 1'b0, 8'd9, 8'd9);
    n_chk++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_bothlow got %b want 1", seq_err); end
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL seq_nooutput[%0d] got %b want 0", k, pix_valid); end
      step();
    end
    // Repeated row 1 while waiting for row 2, then a strobe that lands in the transfer cycle.
    strobe(1'b0, 1'b1, 8'd31, 8'd32);
    strobe(1'b0, 1'b1, 8'd90, 8'd91);
    n_chk++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_repeat_r1 got %b want 1", seq_err); end
    strobe(1'b1, 1'b0, 8'd33, 8'd34);
    strobe(1'b0, 1'b1, 8'd92, 8'd93);
    n_chk++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL seq_xfer got %b want 1", seq_err); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (pix_valid !== 1'b1 || pix_idx !== 2'(i) || pix_data !== e[i])
        begin n_fail++; $display("FAIL seq_frame[%0d] got v%b i%0d d%0d want v1 i%0d d%0d", i, pix_valid, pix_idx, pix_data, i, e[i]); end
      step();
    end
    n_chk++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL seq_done got %b want 0", pix_valid); end
  endtask

  task automatic test_erase();
    logic [7:0] e [4];
    e = '{ex(1), ex(2), ex(3), ex(4)};
    pix_ready = 1'b1;
    strobe(1'b0, 1'b1, 8'd200, 8'd201);
    erase = 1'b1; step(); erase = 1'b0;
    strobe(1'b1, 1'b0, 8'd202, 8'd203);
    n_chk++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL erase_state got seq %b want 1", seq_err); end
    strobe(1'b0, 1'b1, 8'd1, 8'd2);
    strobe(1'b1, 1'b0, 8'd3, 8'd4);
    step();
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (pix_valid !== 1'b1 || pix_idx !== 2'(i) || pix_data !== e[i])
        begin n_fail++; $display("FAIL erase_frame[%0d] got v%b i%0d d%0d want v1 i%0d d%0d", i, pix_valid, pix_idx, pix_data, i, e[i]); end
      step();
    end
    n_chk++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL erase_done got %b want 0", pix_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a [4];
    logic [7:0] b [4];
    a = '{ex(20), ex(21), ex(22), ex(23)};
    b = '{ex(120), ex(121), ex(122), ex(123)};
    pix_ready = 1'b1;
    strobe(1'b0, 1'b1, 8'd20, 8'd21);
    strobe(1'b1, 1'b0, 8'd22, 8'd23);
    step();
    n_chk++; if (pix_idx !== 2'd0 || pix_data !== a[0]) begin n_fail++; $display("FAIL b2b_a0 got i%0d d%0d want i0 d%0d", pix_idx, pix_data, a[0]); end
    strobe(1'b0, 1'b1, 8'd120, 8'd121);
    n_chk++; if (pix_idx !== 2'd1 || pix_data !== a[1]) begin n_fail++; $display("FAIL b2b_a1 got i%0d d%0d want i1 d%0d", pix_idx, pix_data, a[1]); end
    step();
    n_chk++; if (pix_idx !== 2'd2 || pix_data !== a[2]) begin n_fail++; $display("FAIL b2b_a2 got i%0d d%0d want i2 d%0d", pix_idx, pix_data, a[2]); end
    strobe(1'b1, 1'b0, 8'd122, 8'd123);
    n_chk++; if (pix_idx !== 2'd3 || pix_data !== a[3] || pix_last !== 1'b1)
      begin n_fail++; $display("FAIL b2b_a3 got i%0d d%0d l%b want i3 d%0d l1", pix_idx, pix_data, pix_last, a[3]); end
    step();
    n_chk++; if (frame_ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_noovf got %b want 0", frame_ovf); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (pix_valid !== 1'b1 || pix_idx !== 2'(i) || pix_data !== b[i])
        begin n_fail++; $display("FAIL b2b_b[%0d] got v%b i%0d d%0d want v1 i%0d d%0d", i, pix_valid, pix_idx, pix_data, i, b[i]); end
      step();
    end
    n_chk++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_done got %b want 0", pix_valid); end
  endtask

  task automatic test_dark_and_reset();
    logic [7:0] e [4];
    e = '{ex(10), ex(200), ex(16), ex(17)};
    pix_ready = 1'b1;
    strobe(1'b0, 1'b1, 8'd10, 8'd200);
    strobe(1'b1, 1'b0, 8'd16, 8'd17);
    step();
    for (int i = 0; i < 2; i++) begin
      n_chk++; if (pix_data !== e[i]) begin n_fail++; $display("FAIL dark_data[%0d] got %0d want %0d", i, pix_data, e[i]); end
      step();
    end
    n_chk++; if (pix_idx !== 2'd2 || pix_data !== e[2]) begin n_fail++; $display("FAIL dark_idx2 got i%0d d%0d want i2 d%0d", pix_idx, pix_data, e[2]); end
    reset = 1'b0;
    #1;
    n_chk++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", pix_valid); end
    n_chk++; if (pix_idx !== 2'd0 || pix_data !== 8'd0) begin n_fail++; $display("FAIL rst_mid_out got i%0d d%0d want i0 d0", pix_idx, pix_data); end
    step();
    reset = 1'b1;
    step(); step();
    n_chk++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after got %b want 0", pix_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_seq_err();
    test_erase();
    test_back_to_back();
    test_dark_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_readout_buffer.md
# pixel_readout_buffer

Downstream stage of the four-pixel camera controller. It samples the two column ADC outputs on every `adc` strobe while a row-enable (`NRE1`/`NRE2`) is active, assembles a 2x2 frame, and streams the four pixels out over a valid/ready interface. A two-bank (capture/output) buffer lets the next exposure run while the previous frame drains. Frames that cannot be accepted are dropped and flagged.

## Interface
- `ADC_WIDTH`, 8, width of each column ADC sample and of output pixels
- `DARK_LEVEL`, 16, black level subtracted when `DARK_SUB_EN` is defined (must be < 2^ADC_WIDTH)
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  one clock; reset is asynchronous and active-low
- `NRE1`  in  1  row-1 read enable from the camera controller, active-low
- `NRE2`  in  1  row-2 read enable, active-low
- `adc`  in  1  convert strobe, one cycle high per row
- `erase`  in  1  controller erase/idle indication; high aborts a partial capture
- `col1_data`  in  ADC_WIDTH  column-1 ADC result, valid in the cycle `adc`=1
- `col2_data`  in  ADC_WIDTH  column-2 ADC result, valid in the cycle `adc`=1
- `pix_data`  out  ADC_WIDTH  pixel value
- `pix_idx`  out  2  pixel index: 0=R1C1, 1=R1C2, 2=R2C1, 3=R2C2
- `pix_valid`  out  1  `pix_data`/`pix_idx` valid
- `pix_last`  out  1  high with index 3
- `pix_ready`  in  1  consumer accepts when `pix_valid` && `pix_ready`
- `frame_ovf`  out  1  one-cycle pulse: completed frame dropped
- `seq_err`  out  1  one-cycle pulse: protocol violation ignored

## Operation
- Capture FSM states: `WAIT_R1`, `WAIT_R2`, `XFER`.
- `WAIT_R1`: on `adc`=1 with `NRE1`=0, `NRE2`=1 -> store col1/col2 into capture bank slots 0/1, go `WAIT_R2`.
- `WAIT_R2`: on `adc`=1 with `NRE2`=0, `NRE1`=1 -> store slots 2/3, go `XFER`.
- `XFER` (one cycle): if output bank empty, copy capture bank to output bank, mark full; else pulse `frame_ovf`, discard. Always return to `WAIT_R1`.
- `seq_err` pulses, sample ignored, state unchanged when `adc`=1 and: both NRE low; both NRE high; `NRE2`=0 in `WAIT_R1`; `NRE1`=0 in `WAIT_R2` (repeat row 1).
- `erase`=1 in `WAIT_R2` returns to `WAIT_R1` (partial frame discarded, no flag). `erase` has no effect on output bank.
- Output side: when bank full, `pix_valid`=1 with index counter starting at 0; each handshake increments index; handshake at index 3 clears full, index wraps to 0.
- `pix_data`/`pix_idx` held stable while `pix_valid`=1 and `pix_ready`=0.
- Output bank drains only; capture writes never touch it except in `XFER`.

## Timing
- Reset values: `pix_valid`=0, `pix_data`=0, `pix_idx`=0, `pix_last`=0, `frame_ovf`=0, `seq_err`=0; FSM in `WAIT_R1`, both banks empty.
- Row-2 strobe at edge N -> `XFER` at N+1 -> `pix_valid`=1 after edge N+2 (latency 2 cycles).
- Throughput: one pixel per cycle with `pix_ready` held high; frame drains in 4 cycles.
- `XFER` in the same cycle as the last-pixel handshake: bank counts as empty; new frame loaded, `pix_valid` stays 1, index 0, no gap, no `frame_ovf`.
- `adc` strobe during `XFER` is ignored and flags `seq_err`.
- Reset asserted mid-frame or mid-stream: all state cleared immediately, stream aborted.

## Configuration
- `DARK_SUB_EN` defined: samples stored as `max(sample - DARK_LEVEL, 0)`, saturating at 0, computed at capture.
- Not defined: samples stored unmodified; `DARK_LEVEL` unused.

## Test plan
- Reset, row1 strobe col=(40,50), row2 strobe col=(60,70), `pix_ready`=1 -> pixels 40,50,60,70 idx 0..3, `pix_last` on 70, valid 2 cycles after row-2 strobe (DARK_SUB_EN: 24,34,44,54).
- `pix_ready` low during stream -> data/idx held; resumes without loss.
- Second frame completes while first not drained (`pix_ready`=0) -> `frame_ovf` pulse, first frame still output intact.
- Row-2 strobe first, then both NRE low with strobe -> two `seq_err` pulses, no output.
- Row1 captured, `erase`=1, then full frame (1,2,3,4) -> only 1,2,3,4 output.
- DARK_SUB_EN with sample 10 -> output 0; reset mid-stream at idx 2 -> `pix_valid`=0 immediately.
